// File: rtl/imm_encoder_pkg.sv
// Shared encodings for the RV32I immediate encoder: instruction formats,
// opcode constants, FSM states and a signed-range helper.
package imm_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHIFT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6,
    FMT_RSVD  = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // True when v[31:bits-1] are all equal, i.e. v fits a bits-wide signed field.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response stream bundle between an instruction producer and the encoder.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err
  );
endinterface

// File: rtl/imm_encoder_pack_chk.sv
// Combinational RV32I word packer with immediate range check.
// Fields not used by a format are left at zero; fmt=7 yields a zero word flagged as error.
module imm_pack_chk
  import imm_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  always_comb begin
    inst = '0;
    err  = 1'b0;
    case (fmt_e'(fmt))
      FMT_R: begin
        inst = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        err  = !fits_signed(imm, 12);
      end
      FMT_SHIFT: begin
        inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        err  = |imm[31:5];
      end
      FMT_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !fits_signed(imm, 12);
      end
      FMT_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = imm[0] || !fits_signed(imm, 13);
      end
      FMT_U: begin
        inst = {imm[31:12], rd, opcode};
        err  = |imm[11:0];
      end
      FMT_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = imm[0] || !fits_signed(imm, 21);
      end
      default: begin
        inst = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Streaming RV32I instruction encoder: one output register, running address,
// range checking and halt-on-error. Optional counters under IMM_ENCODER_STATS_EN.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP   = 32'd4,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  imm_encoder_if.slave bus,
  input  logic         clr_halt,
  output logic         halted
`ifdef IMM_ENCODER_STATS_EN
  ,
  output logic [15:0]  err_cnt,
  output logic [31:0]  inst_cnt
`endif
);

  state_e      state_q;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q,  out_inst_d;
  logic [31:0] out_addr_q,  out_addr_d;
  logic        out_err_q,   out_err_d;
  logic [31:0] next_addr_q, next_addr_d;
  logic [31:0] pack_inst;
  logic        pack_err;
  logic        in_ready;
  logic        accept;

  imm_pack_chk u_pack (
    .fmt    (bus.fmt),
    .opcode (bus.opcode),
    .funct3 (bus.funct3),
    .funct7 (bus.funct7),
    .rd     (bus.rd),
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .imm    (bus.imm),
    .inst   (pack_inst),
    .err    (pack_err)
  );

  // The output slot frees up in the same cycle it drains, allowing one word per cycle.
  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    next_addr_d = next_addr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = pack_inst;
      out_addr_d  = next_addr_q;
      out_err_d   = pack_err;
      next_addr_d = next_addr_q + ADDR_STEP;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= BASE_ADDR;
      out_err_q   <= 1'b0;
      next_addr_q <= BASE_ADDR;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      next_addr_q <= next_addr_d;
    end
  end

  // Halt is entered on the same edge that loads the erroneous word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (accept && pack_err && HALT_ON_ERR) state_q <= ST_HALT;
        ST_HALT: if (clr_halt) state_q <= ST_RUN;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_err   = out_err_q;
  assign halted        = (state_q == ST_HALT);

`ifdef IMM_ENCODER_STATS_EN
  logic [15:0] err_cnt_q,  err_cnt_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;

  always_comb begin
    err_cnt_d  = err_cnt_q;
    inst_cnt_d = inst_cnt_q;
    if (accept && (inst_cnt_q != '1)) inst_cnt_d = inst_cnt_q + 32'd1;
    if (accept && pack_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q  <= '0;
      inst_cnt_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign inst_cnt = inst_cnt_q;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed test-plan vectors, then randomized traffic
// checked against an arithmetic reference model and an expected-word queue.
module tb_imm_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
  localparam logic [31:0] STEP = 32'd4;

  typedef struct {
    int unsigned fmt, op, f3, f7, rd, rs1, rs2, imm;
  } req_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_halt = 1'b0;
  logic halted;
`ifdef IMM_ENCODER_STATS_EN
  logic [15:0] err_cnt;
  logic [31:0] inst_cnt;
`endif

  imm_encoder_if bus ();

  imm_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP), .HALT_ON_ERR(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .clr_halt (clr_halt),
    .halted   (halted)
`ifdef IMM_ENCODER_STATS_EN
    ,
    .err_cnt  (err_cnt),
    .inst_cnt (inst_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  logic [31:0] m_addr;
  bit          m_halt;
  int unsigned m_inst_cnt, m_err_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Reference encoder written from the field layout with shifts and integer ranges.
  function automatic void model(input req_t r, output logic [31:0] w, output logic e);
    int s;
    int unsigned m, lo;
    s  = $signed(r.imm);
    m  = r.imm;
    lo = (r.rd << 7) | r.op;
    w  = 0;
    e  = 1'b0;
    case (r.fmt)
      0: w = (r.f7 << 25) | (r.rs2 << 20) | (r.rs1 << 15) | (r.f3 << 12) | lo;
      1: begin
        w = ((m & 32'hFFF) << 20) | (r.rs1 << 15) | (r.f3 << 12) | lo;
        e = (s < -2048) || (s > 2047);
      end
      2: begin
        w = (r.f7 << 25) | ((m & 31) << 20) | (r.rs1 << 15) | (r.f3 << 12) | lo;
        e = m > 31;
      end
      3: begin
        w = (((m >> 5) & 32'h7F) << 25) | (r.rs2 << 20) | (r.rs1 << 15) | (r.f3 << 12)
            | ((m & 31) << 7) | r.op;
        e = (s < -2048) || (s > 2047);
      end
      4: begin
        w = (((m >> 12) & 1) << 31) | (((m >> 5) & 63) << 25) | (r.rs2 << 20) | (r.rs1 << 15)
            | (r.f3 << 12) | (((m >> 1) & 15) << 8) | (((m >> 11) & 1) << 7) | r.op;
        e = (m % 2 == 1) || (s < -4096) || (s > 4095);
      end
      5: begin
        w = (m & 32'hFFFF_F000) | lo;
        e = (m % 4096) != 0;
      end
      6: begin
        w = (((m >> 20) & 1) << 31) | (((m >> 1) & 32'h3FF) << 21) | (((m >> 11) & 1) << 20)
            | (((m >> 12) & 32'hFF) << 12) | lo;
        e = (m % 2 == 1) || (s < -1048576) || (s > 1048575);
      end
      default: begin
        w = 0;
        e = 1'b1;
      end
    endcase
  endfunction

  task automatic drive(input req_t r);
    bus.fmt    = 3'(r.fmt);
    bus.opcode = 7'(r.op);
    bus.funct3 = 3'(r.f3);
    bus.funct7 = 7'(r.f7);
    bus.rd     = 5'(r.rd);
    bus.rs1    = 5'(r.rs1);
    bus.rs2    = 5'(r.rs2);
    bus.imm    = r.imm;
  endtask

  function automatic req_t mk(input int unsigned fmt, op, f3, f7, rd, rs1, rs2, imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.f3 = f3; r.f7 = f7;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  // One clock: sample just after the falling edge, score, then advance to the next falling edge.
  task automatic tick();
    bit          fire_in, fire_out, empty;
    logic [31:0] w;
    logic        e;
    req_t        r;
    exp_t        x;
    #1;
    empty = (exp_q.size() == 0);
    chk("out_valid", 32'(bus.out_valid), 32'(!empty));
    chk("in_ready", 32'(bus.in_ready), 32'(!m_halt && (empty || bus.out_ready)));
    chk("halted", 32'(halted), 32'(m_halt));
`ifdef IMM_ENCODER_STATS_EN
    chk("inst_cnt", inst_cnt, m_inst_cnt);
    chk("err_cnt", 32'(err_cnt), m_err_cnt);
`endif
    if (!empty) begin
      x = exp_q[0];
      chk("out_inst", bus.out_inst, x.inst);
      chk("out_addr", bus.out_addr, x.addr);
      chk("out_err", 32'(bus.out_err), 32'(x.err));
    end
    fire_out = !empty && bus.out_ready;
    fire_in  = bus.in_valid && !m_halt && (empty || bus.out_ready);
    if (fire_out) void'(exp_q.pop_front());
    if (fire_in) begin
      r = mk(bus.fmt, bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1, bus.rs2, bus.imm);
      model(r, w, e);
      x.inst = w; x.addr = m_addr; x.err = e;
      exp_q.push_back(x);
      m_addr = m_addr + STEP;
      if (m_inst_cnt != 32'hFFFF_FFFF) m_inst_cnt++;
      if (e && m_err_cnt != 32'hFFFF) m_err_cnt++;
      if (e) m_halt = 1'b1;
    end else if (m_halt && clr_halt) begin
      m_halt = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int unsigned rand_imm();
    case ($urandom % 7)
      0: return $urandom;
      1: return $urandom_range(0, 8191) - 4096;
      2: return $urandom_range(0, 40);
      3: return $urandom & 32'hFFFF_F000;
      4: return ($urandom_range(0, 32'h3F_FFFF) - 32'h20_0000) & ~32'd1;
      5: return $urandom_range(0, 1) ? 32'h0000_0800 : 32'hFFFF_F7FF;
      default: return $urandom_range(0, 4) - 2;
    endcase
  endfunction

  initial begin
    req_t r;
    logic [31:0] held_inst;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    m_addr = BASE; m_halt = 1'b0; m_inst_cnt = 0; m_err_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_out_addr", bus.out_addr, BASE);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // addi x1, x0, -1
    bus.out_ready = 1'b1;
    drive(mk(1, 7'b0010011, 0, 0, 1, 0, 0, 32'hFFFF_FFFF));
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("addi_inst", bus.out_inst, 32'hFFF0_0093);
    chk("addi_addr", bus.out_addr, BASE);
    chk("addi_err", 32'(bus.out_err), 32'd0);
    tick();

    // sw then beq back to back
    drive(mk(3, 7'b0100011, 3'b010, 0, 0, 1, 2, 32'd8));
    bus.in_valid = 1'b1;
    tick();
    chk("sw_inst", bus.out_inst, 32'h0020_A423);
    drive(mk(4, 7'b1100011, 0, 0, 0, 0, 0, 32'hFFFF_FFFC));
    tick();
    chk("beq_inst", bus.out_inst, 32'hFE00_0EE3);
    chk("beq_addr", bus.out_addr, BASE + 32'd8);

    // lui then jal; jal's address wraps past 2^32
    drive(mk(5, 7'b0110111, 0, 0, 5, 0, 0, 32'h1234_5000));
    tick();
    chk("lui_inst", bus.out_inst, 32'h1234_52B7);
    drive(mk(6, 7'b1101111, 0, 0, 1, 0, 0, 32'h0000_0800));
    tick();
    chk("jal_inst", bus.out_inst, 32'h0010_00EF);
    chk("jal_addr_wrap", bus.out_addr, 32'h0000_0000);

    // Backpressure: hold out_ready low for three cycles with a request pending
    bus.out_ready = 1'b0;
    drive(mk(0, 7'b0110011, 0, 7'b0100000, 3, 4, 5, 0));
    tick();
    held_inst = bus.out_inst;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", bus.out_inst, held_inst);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(mk(1, 7'b0010011, 0, 0, i + 1, 0, 0, i * 16));
      tick();
    end
    bus.in_valid = 1'b0;
    tick();

    // Error halt
    drive(mk(1, 7'b0010011, 0, 0, 0, 0, 0, 32'h0000_0800));
    bus.in_valid = 1'b1;
    tick();
    chk("err_inst", bus.out_inst, 32'h8000_0013);
    chk("err_flag", 32'(bus.out_err), 32'd1);
    chk("err_halted", 32'(halted), 32'd1);
    chk("err_in_ready", 32'(bus.in_ready), 32'd0);
    drive(mk(1, 7'b0010011, 0, 0, 7, 0, 0, 32'd5));
    tick();
    tick();
    clr_halt = 1'b1;
    tick();
    clr_halt = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();

    // Asynchronous reset with a word pending
    bus.out_ready = 1'b0;
    drive(mk(5, 7'b0010111, 0, 0, 9, 0, 0, 32'hABCD_E000));
    bus.in_valid = 1'b1;
    tick();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_addr", bus.out_addr, BASE);
`ifdef IMM_ENCODER_STATS_EN
    chk("async_rst_inst_cnt", inst_cnt, 32'd0);
    chk("async_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    exp_q.delete();
    m_addr = BASE; m_halt = 1'b0; m_inst_cnt = 0; m_err_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("post_rst_addr", bus.out_addr, BASE);
    bus.in_valid = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = mk($urandom % 8, $urandom % 128, $urandom % 8, $urandom % 128,
             $urandom % 32, $urandom % 32, $urandom % 32, rand_imm());
      drive(r);
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      clr_halt      = ($urandom % 6) == 0;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    clr_halt      = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
